// File: rtl/reg_ctx_engine_pkg.sv
// Shared types and constants for the LC-3 register-file context save/restore engine.
package lc3_ctx_pkg;

    localparam int   NUM_REGS   = 8;
    localparam logic OP_SAVE    = 1'b0;
    localparam logic OP_RESTORE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ACQ,
        RD,
        MEM,
        WR,
        DONE
    } ctx_state_t;

endpackage

// File: rtl/reg_ctx_engine_if.sv
// Control, register-file and memory signals of the context engine, with engine (master) and environment (slave) views.
interface reg_ctx_engine_if #(
    parameter int NUM_REGS = 8,
    parameter int DW       = 16
);
    import lc3_ctx_pkg::*;

    localparam int IW = $clog2(NUM_REGS);

    logic                Start;
    logic                Op;
    logic [NUM_REGS-1:0] Mask;
    logic [DW-1:0]       Base;
    logic                Busy;
    logic                Done;
    ctx_state_t          dbg_state;

    // Rf_Req is held from acquisition through the last access; the arbiter keeps Rf_Gnt
    // high while Rf_Req is high. A memory transfer completes in a cycle with Mem_Req && Mem_Ack.
    logic                Rf_Req;
    logic                Rf_Gnt;
    logic [IW-1:0]       Rf_Sel;
    logic [DW-1:0]       Rf_Rdata;
    logic                Rf_Ld;
    logic [IW-1:0]       Rf_Dr;
    logic [DW-1:0]       Rf_Wdata;

    logic                Mem_Req;
    logic                Mem_We;
    logic [DW-1:0]       Mem_Addr;
    logic [DW-1:0]       Mem_Wdata;
    logic [DW-1:0]       Mem_Rdata;
    logic                Mem_Ack;

    modport master (
        input  Start, Op, Mask, Base, Rf_Gnt, Rf_Rdata, Mem_Rdata, Mem_Ack,
        output Busy, Done, dbg_state, Rf_Req, Rf_Sel, Rf_Ld, Rf_Dr, Rf_Wdata,
               Mem_Req, Mem_We, Mem_Addr, Mem_Wdata
    );

    modport slave (
        output Start, Op, Mask, Base, Rf_Gnt, Rf_Rdata, Mem_Rdata, Mem_Ack,
        input  Busy, Done, dbg_state, Rf_Req, Rf_Sel, Rf_Ld, Rf_Dr, Rf_Wdata,
               Mem_Req, Mem_We, Mem_Addr, Mem_Wdata
    );

endinterface

// File: rtl/reg_ctx_engine_next_idx.sv
// Priority finder: lowest set mask bit, either from bit 0 (incl_i) or strictly above cur_i.
module ctx_next_idx #(
    parameter int NUM_REGS = 8,
    parameter int IW       = $clog2(NUM_REGS)
) (
    input  logic [NUM_REGS-1:0] mask_i,
    input  logic [IW-1:0]       cur_i,
    input  logic                incl_i,
    output logic [IW-1:0]       idx_o,
    output logic                found_o
);
    import lc3_ctx_pkg::*;

    // Scan downward so the lowest qualifying bit is the last one written.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (mask_i[i] && (incl_i || (i > int'(cur_i)))) begin
                idx_o   = IW'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_ctx_engine.sv
// Context save/restore sequencer: walks masked registers between the register file and memory.
module reg_ctx_engine #(
    parameter int NUM_REGS = 8,
    parameter int DW       = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    reg_ctx_engine_if.master  bus
);
    import lc3_ctx_pkg::*;

    localparam int IW = $clog2(NUM_REGS);

    ctx_state_t          state_q, state_d;
    logic                op_q, op_d;
    logic [NUM_REGS-1:0] mask_q, mask_d;
    logic [DW-1:0]       base_q, base_d;
    logic [DW-1:0]       hold_q, hold_d;
    logic [IW-1:0]       idx_q, idx_d;

    logic [NUM_REGS-1:0] srch_mask;
    logic                srch_incl;
    logic [IW-1:0]       nxt_idx;
    logic                nxt_found;
    ctx_state_t          adv_state;
    logic [IW-1:0]       adv_idx;
    logic [DW-1:0]       mem_addr;

    // In IDLE the finder sees the incoming mask to pick the first register; afterwards it advances.
    assign srch_incl = (state_q == IDLE);
    assign srch_mask = srch_incl ? bus.Mask : mask_q;

    ctx_next_idx #(.NUM_REGS(NUM_REGS), .IW(IW)) u_next_idx (
        .mask_i  (srch_mask),
        .cur_i   (idx_q),
        .incl_i  (srch_incl),
        .idx_o   (nxt_idx),
        .found_o (nxt_found)
    );

    assign adv_state = !nxt_found ? DONE : ((op_q == OP_SAVE) ? RD : MEM);
    assign adv_idx   = nxt_found ? nxt_idx : idx_q;
    assign mem_addr  = base_q + {{(DW-IW){1'b0}}, idx_q};

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        mask_d        = mask_q;
        base_d        = base_q;
        hold_d        = hold_q;
        idx_d         = idx_q;
        bus.Busy      = (state_q != IDLE);
        bus.Done      = 1'b0;
        bus.dbg_state = state_q;
        bus.Rf_Req    = 1'b0;
        bus.Rf_Sel    = '0;
        bus.Rf_Ld     = 1'b0;
        bus.Rf_Dr     = '0;
        bus.Rf_Wdata  = '0;
        bus.Mem_Req   = 1'b0;
        bus.Mem_We    = 1'b0;
        bus.Mem_Addr  = '0;
        bus.Mem_Wdata = '0;

        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    op_d    = bus.Op;
                    mask_d  = bus.Mask;
                    base_d  = bus.Base;
                    idx_d   = nxt_idx;
                    state_d = nxt_found ? ACQ : DONE;
                end
            end
            ACQ: begin
                bus.Rf_Req = 1'b1;
                if (bus.Rf_Gnt) state_d = (op_q == OP_SAVE) ? RD : MEM;
            end
            RD: begin
                bus.Rf_Req = 1'b1;
                bus.Rf_Sel = idx_q;
                hold_d     = bus.Rf_Rdata;
                state_d    = MEM;
            end
            MEM: begin
                // Address, direction and data come from registers, so they hold steady across waits.
                bus.Rf_Req    = 1'b1;
                bus.Mem_Req   = 1'b1;
                bus.Mem_We    = (op_q == OP_SAVE);
                bus.Mem_Addr  = mem_addr;
                bus.Mem_Wdata = hold_q;
                if (bus.Mem_Ack) begin
                    if (op_q == OP_SAVE) begin
                        state_d = adv_state;
                        idx_d   = adv_idx;
                    end else begin
                        hold_d  = bus.Mem_Rdata;
                        state_d = WR;
                    end
                end
            end
            WR: begin
                bus.Rf_Req   = 1'b1;
                bus.Rf_Ld    = 1'b1;
                bus.Rf_Dr    = idx_q;
                bus.Rf_Wdata = hold_q;
                state_d      = adv_state;
                idx_d        = adv_idx;
            end
            DONE: begin
                bus.Done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            op_q    <= 1'b0;
            mask_q  <= '0;
            base_q  <= '0;
            hold_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            mask_q  <= mask_d;
            base_q  <= base_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
        end
    end

endmodule
